button_conditioner: RTL and testbench

//   Conditions one raw push-button pin into clean control events for the pixel

---
 rtl/button_conditioner.sv | 131 +++++++++++++
 tb/tb_button_conditioner.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce, press/release strobes
// and hold-to-repeat, all in the consumer's clock domain.
module button_conditioner #(
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned DEBOUNCE_CYCLES = 250_000,
    parameter int unsigned REPEAT_EN       = 1,
    parameter int unsigned REPEAT_DELAY    = 12_500_000,
    parameter int unsigned REPEAT_PERIOD   = 2_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse,
    output logic action_pulse
);

    localparam int unsigned RepMax =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned DbW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned RepW = (RepMax > 1) ? $clog2(RepMax) : 1;

    localparam logic            PinIdle    = (ACTIVE_LOW != 0);
    localparam logic            RepEnable  = (REPEAT_EN != 0);
    localparam logic [DbW-1:0]  DbLast     = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
    localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat} rep_state_e;

    logic            s0_q, s1_q;
    logic            act;
    logic [DbW-1:0]  db_cnt_q, db_cnt_d;
    logic            pressed_q, pressed_d;
    logic            rise, fall;
    rep_state_e      state_q, state_d;
    logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
    logic            rep;
    logic            press_q, release_q, repeat_q, action_q;

    always_comb begin
        act       = PinIdle ? ~s1_q : s1_q;
        db_cnt_d  = '0;
        pressed_d = pressed_q;
        rise      = 1'b0;
        fall      = 1'b0;
        if (act != pressed_q) begin
            if (db_cnt_q == DbLast) begin
                pressed_d = act;
                rise      = act;
                fall      = ~act;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // A release edge always returns to idle and suppresses a coincident repeat.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        rep       = 1'b0;
        if (fall || !RepEnable) begin
            state_d   = StIdle;
            rep_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rep_cnt_d = '0;
                    if (rise) state_d = StDelay;
                end
                StDelay: begin
                    if (rep_cnt_q == DelayLast) begin
                        rep       = 1'b1;
                        state_d   = StRepeat;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                StRepeat: begin
                    if (rep_cnt_q == PeriodLast) begin
                        rep       = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d   = StIdle;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_q      <= PinIdle;
            s1_q      <= PinIdle;
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
            state_q   <= StIdle;
            rep_cnt_q <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            action_q  <= 1'b0;
        end else begin
            s0_q      <= btn_in;
            s1_q      <= s0_q;
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
            state_q   <= state_d;
            rep_cnt_q <= rep_cnt_d;
            press_q   <= rise;
            release_q <= fall;
            repeat_q  <= rep;
            action_q  <= rise | rep;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign repeat_pulse  = repeat_q;
    assign action_pulse  = action_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: two instances (repeat on/off) against a windowed
// history model of debounce and arithmetic repeat schedule.
module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic clk, rst, btn_in;
    logic pressed, press_pulse, release_pulse, repeat_pulse, action_pulse;
    logic nr_pressed, nr_press, nr_release, nr_repeat, nr_action;
    logic [4:0] dut_vec, nr_vec, exp_vec, exp_nr;

    int checks = 0;
    int passed = 0;
    int k = 0;
    int t_press = 0;
    int hold_tp = 0;
    logic m_pressed;
    logic q[$];
    logic u[$];

    button_conditioner #(
        .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .btn_in(btn_in), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .action_pulse(action_pulse)
    );

    button_conditioner #(
        .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(DB), .REPEAT_EN(0),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_norep (
        .clk(clk), .rst(rst), .btn_in(btn_in), .pressed(nr_pressed),
        .press_pulse(nr_press), .release_pulse(nr_release),
        .repeat_pulse(nr_repeat), .action_pulse(nr_action)
    );

    assign dut_vec = {pressed, press_pulse, release_pulse, repeat_pulse, action_pulse};
    assign nr_vec  = {nr_pressed, nr_press, nr_release, nr_repeat, nr_action};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        q = {1'b0, 1'b0};
        u.delete();
        m_pressed = 1'b0;
        exp_vec = '0;
        exp_nr = '0;
    endtask

    // Debounce: pressed flips once the last DB synchronized samples (two edges old)
    // all disagree with it; repeats fall at press + RD + n*RP while still held.
    task automatic step();
        logic used, all_diff, rise, fall, rep;
        @(posedge clk);
        k++;
        if (rst) begin
            model_reset();
        end else begin
            used = q[q.size()-2];
            q.push_back(~btn_in);
            void'(q.pop_front());
            u.push_back(used);
            if (u.size() > DB) void'(u.pop_front());
            all_diff = (u.size() == DB);
            foreach (u[i]) if (u[i] == m_pressed) all_diff = 1'b0;
            rise = all_diff && !m_pressed;
            fall = all_diff && m_pressed;
            rep  = m_pressed && !fall && (k - t_press >= RD) && ((k - t_press - RD) % RP == 0);
            if (rise) t_press = k;
            if (all_diff) begin
                m_pressed = ~m_pressed;
                u.delete();
            end
            exp_vec = {m_pressed, rise, fall, rep, rise | rep};
            exp_nr  = {m_pressed, rise, fall, 1'b0, rise};
        end
        #1;
    endtask

    task automatic test_reset();
        int rise_n = -1;
        int pp = 0;
        rst = 1'b1;
        btn_in = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL reset_hold edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
        end
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL reset_release edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            if (pressed && rise_n < 0) rise_n = n;
            if (press_pulse) pp++;
        end
        checks++;
        if (rise_n !== 2 + DB) $display("FAIL reset_latency: got %0d need %0d", rise_n, 2 + DB);
        else passed++;
        checks++;
        if (pp !== 1) $display("FAIL reset_press_width: got %0d need 1", pp);
        else passed++;
    endtask

    task automatic test_glitch();
        int pulses = 0;
        int held = 0;
        btn_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL glitch_settle edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
        end
        for (int i = 0; i < 15; i++) begin
            btn_in = (i < 3) ? 1'b0 : 1'b1;
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL glitch edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            pulses += press_pulse + release_pulse + repeat_pulse + action_pulse;
            held += pressed;
        end
        checks++;
        if (pulses + held !== 0) $display("FAIL glitch_quiet: got %0d events need 0", pulses + held);
        else passed++;
    endtask

    task automatic test_hold_repeat();
        int tp = -1;
        int nrep = 0;
        int nact = 0;
        int bad_off = 0;
        int exp_rep;
        logic [3:0] prev = '0;
        logic wide = 1'b0;
        btn_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL hold edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            if (press_pulse && tp < 0) tp = k;
            if (repeat_pulse) begin
                if (tp < 0 || k - tp != RD + RP * nrep) bad_off++;
                nrep++;
            end
            nact += action_pulse;
            if ((prev & dut_vec[3:0]) != 0) wide = 1'b1;
            prev = dut_vec[3:0];
        end
        hold_tp = tp;
        exp_rep = (tp >= 0 && k - tp >= RD) ? (k - tp - RD) / RP + 1 : 0;
        checks++;
        if (bad_off !== 0) $display("FAIL repeat_offsets: got %0d misplaced need 0", bad_off);
        else passed++;
        checks++;
        if (nrep !== exp_rep || tp < 0)
            $display("FAIL repeat_count: got %0d need %0d (press edge %0d)", nrep, exp_rep, tp);
        else passed++;
        checks++;
        if (nact !== 1 + nrep) $display("FAIL action_count: got %0d need %0d", nact, 1 + nrep);
        else passed++;
        checks++;
        if (wide !== 1'b0) $display("FAIL pulse_width: got wide=%b need 0", wide);
        else passed++;
    endtask

    task automatic test_release_on_repeat();
        int f = hold_tp + RD;
        int rel_edge = -1;
        int late_rep = 0;
        int nrel = 0;
        while (f < k + 7) f += RP;
        btn_in = 1'b0;
        while (k < f - 6) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL rel_pre edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
        end
        btn_in = 1'b1;
        while (k < f + 8) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL rel_post edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            if (release_pulse) begin
                nrel++;
                rel_edge = k;
            end
            if (k >= f && repeat_pulse) late_rep++;
        end
        checks++;
        if (rel_edge !== f || nrel !== 1)
            $display("FAIL release_edge: got edge %0d x%0d need edge %0d x1", rel_edge, nrel, f);
        else passed++;
        checks++;
        if (late_rep !== 0) $display("FAIL release_wins: got %0d repeats need 0", late_rep);
        else passed++;
    endtask

    task automatic test_async_reset();
        int seen = 0;
        int rise_n = -1;
        int pp = 0;
        btn_in = 1'b0;
        for (int i = 0; i < 60 && seen < 2; i++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL arst_pre edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            seen += repeat_pulse;
        end
        checks++;
        if (seen < 2) $display("FAIL arst_reach_repeat: got %0d repeats need 2", seen);
        else passed++;
        #3 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
            $display("FAIL arst_immediate: got %b/%b need %b/%b", dut_vec, nr_vec, exp_vec, exp_nr);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL arst_hold edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
        end
        rst = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL arst_release edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            if (pressed && rise_n < 0) rise_n = n;
            pp += press_pulse;
        end
        checks++;
        if (rise_n !== 2 + DB || pp !== 1)
            $display("FAIL arst_redetect: got edge %0d x%0d need edge %0d x1", rise_n, pp, 2 + DB);
        else passed++;
    endtask

    task automatic test_norep();
        int np = 0;
        int nr = 0;
        btn_in = 1'b1;
        for (int i = 0; i < 52; i++) begin
            if (i == 12) btn_in = 1'b0;
            step();
            checks++;
            if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                $display("FAIL norep edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                         exp_vec, exp_nr);
            else passed++;
            if (i >= 12) begin
                np += nr_press;
                nr += nr_repeat;
            end
        end
        checks++;
        if (np !== 1 || nr !== 0)
            $display("FAIL norep_counts: got press %0d repeat %0d need 1 and 0", np, nr);
        else passed++;
    endtask

    task automatic test_random();
        int run;
        for (int r = 0; r < 60; r++) begin
            btn_in = 1'($urandom_range(0, 1));
            run = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                model_reset();
            end
            for (int i = 0; i < run; i++) begin
                step();
                if (i == 1) rst = 1'b0;
                checks++;
                if ({dut_vec, nr_vec} !== {exp_vec, exp_nr})
                    $display("FAIL random edge %0d: got %b/%b need %b/%b", k, dut_vec, nr_vec,
                             exp_vec, exp_nr);
                else passed++;
            end
            rst = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        btn_in = 1'b0;
        model_reset();
        test_reset();
        test_glitch();
        test_hold_repeat();
        test_release_on_repeat();
        test_async_reset();
        test_norep();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
